// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register file geometry and the register
// exposed as the return value, so pipeline, decode and register file agree.
package cpu_pkg;

    localparam int CPU_DATA_W  = 16;
    localparam int CPU_ADDR_W  = 3;
    localparam int CPU_RET_REG = 3;

endpackage : cpu_pkg

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when a load is issued
// (mark) and cleared when that load writes back (clr). Queries return the
// post-update state so decode sees same-cycle marks and clears.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] qaddr0,
    input  logic [ADDR_W-1:0] qaddr1,
    output logic              pend_next0,
    output logic              pend_next1
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Next pending state: a new mark wins over a returning load; register 0
    // can never be marked, so its bit stays at its reset value of 0.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = (mark_en && (mark_addr == ADDR_W'(i)) && (i != 0))
                     || (pend_q[i] && !(clr_en && (clr_addr == ADDR_W'(i))));
        end
    end

    // Pending bit storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_next0 = pend_d[qaddr0];
    assign pend_next1 = pend_d[qaddr1];

endmodule : reg_scoreboard

// File: rtl/regfile_2w_sb.sv
// Two-write, two-read register file with registered write-first reads,
// stall hold, and a pending-load scoreboard for load-use hazard detection.
module regfile_2w_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int RET_REG = CPU_RET_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rbusy0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rbusy1,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic [DATA_W-1:0] ret_val
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rbusy0_q, rbusy0_d;
    logic              rbusy1_q, rbusy1_d;

    logic              pend_next0;
    logic              pend_next1;

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .mark_en    (mark_en),
        .mark_addr  (mark_addr),
        .clr_en     (wen1),
        .clr_addr   (waddr1),
        .qaddr0     (raddr0),
        .qaddr1     (raddr1),
        .pend_next0 (pend_next0),
        .pend_next1 (pend_next1)
    );

    // Post-write array contents: port 0 beats port 1 on the same address and
    // register 0 is never written. Reads index this same vector, which gives
    // write-first bypass with exactly the write priority.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
            if (i != 0) begin
                if (wen0 && (waddr0 == ADDR_W'(i))) begin
                    mem_d[i] = wdata0;
                end else if (wen1 && (waddr1 == ADDR_W'(i))) begin
                    mem_d[i] = wdata1;
                end
            end
        end
    end

    // Read-side next state: capture bypassed data and post-update pending
    // flags when enabled, otherwise hold for the stalled stage.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rbusy0_d = rbusy0_q;
        rbusy1_d = rbusy1_q;
        if (ren) begin
            rdata0_d = mem_d[raddr0];
            rdata1_d = mem_d[raddr1];
            rbusy0_d = pend_next0;
            rbusy1_d = pend_next1;
        end
    end

    // Array and read-output registers; reset clears everything and overrides
    // any same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
            rbusy0_q <= 1'b0;
            rbusy1_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rbusy0_q <= rbusy0_d;
            rbusy1_q <= rbusy1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rbusy0  = rbusy0_q;
    assign rbusy1  = rbusy1_q;
    assign ret_val = mem_q[RET_REG];

endmodule : regfile_2w_sb
